// File: rtl/free_list_if.sv
// free_list_if: rename-stage <-> free list bundle.
//   dispatch_req  3 bits        slot i wants a new PR
//   retire_en     3 bits        slot i retires and frees told_in[i]
//   told_in       3 x PR        Told tags being freed
//   BPRecoverEN   1 bit         mispredict recovery
//   free_pr       3 x PR        PR offered to slot i
//   alloc_grant   3 bits        slot i granted this cycle
//   avail_num     2 bits        min(free_count, 3)
//   free_count    CntW bits     number of free PRs
// The master is the rename stage; the slave is the free list.
interface free_list_if #(
    parameter int unsigned PR    = 6,
    parameter int unsigned DEPTH = 32
);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [2:0]           dispatch_req;
    logic [2:0]           retire_en;
    logic [2:0][PR-1:0]   told_in;
    logic                 BPRecoverEN;
    logic [2:0][PR-1:0]   free_pr;
    logic [2:0]           alloc_grant;
    logic [1:0]           avail_num;
    logic [CntW-1:0]      free_count;

    modport master (
        output dispatch_req, retire_en, told_in, BPRecoverEN,
        input  free_pr, alloc_grant, avail_num, free_count
    );

    modport slave (
        input  dispatch_req, retire_en, told_in, BPRecoverEN,
        output free_pr, alloc_grant, avail_num, free_count
    );
endinterface

// File: rtl/free_list.sv
// free_list: circular free list of physical registers for a 3-wide rename stage.
// Ports:
//   clock  in  rising-edge clock
//   reset  in  synchronous, active-high; wins over every other input
//   bus    free_list_if.slave: allocation requests/grants, retire frees, recovery
// Allocation is combinational from the registered state (zero latency); retires push
// Told tags at the tail. Recovery rewinds head to the architectural head and marks
// the list full again in a single cycle.
module free_list #(
    parameter int unsigned PR        = 6,
    parameter int unsigned NUM_PR    = 2 ** PR,
    parameter int unsigned ARCH_REGS = 32,
    parameter int unsigned DEPTH     = NUM_PR - ARCH_REGS
) (
    input logic         clock,
    input logic         reset,
    free_list_if.slave  bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [PR-1:0]   entry_q [DEPTH];
    logic [PR-1:0]   entry_d [DEPTH];
    logic [PtrW-1:0] head_q, head_d;
    logic [PtrW-1:0] tail_q, tail_d;
    logic [PtrW-1:0] arch_head_q, arch_head_d;
    logic [CntW-1:0] count_q, count_d;

    logic [1:0]         avail;
    logic [2:0]         grant;
    logic [1:0]         n_grant;
    logic [1:0]         n_ret;
    logic [2:0][PR-1:0] pr_sel;

    // Pointer advance modulo DEPTH; k is at most 3, so one subtraction suffices.
    function automatic logic [PtrW-1:0] ptr_add(input logic [PtrW-1:0] p, input logic [1:0] k);
        int unsigned s;
        s = 32'(p) + 32'(k);
        if (s >= DEPTH) s = s - DEPTH;
        return s[PtrW-1:0];
    endfunction

    // Grants in slot order. A requesting slot sees the entry its grant would take;
    // an idle slot previews entry[head+i] so the next three free PRs are visible.
    always_comb begin
        avail   = (count_q >= CntW'(3)) ? 2'd3 : count_q[1:0];
        grant   = '0;
        n_grant = '0;
        pr_sel  = '0;
        for (int i = 0; i < 3; i++) begin
            if (bus.dispatch_req[i]) begin
                pr_sel[i] = entry_q[ptr_add(head_q, n_grant)];
                if (!bus.BPRecoverEN && (n_grant < avail)) begin
                    grant[i] = 1'b1;
                    n_grant  = n_grant + 2'd1;
                end
            end else begin
                pr_sel[i] = entry_q[ptr_add(head_q, 2'(i))];
            end
        end
    end

    // Retire pushes and next-state. Grants use the pre-retire count (no same-cycle bypass).
    always_comb begin
        entry_d = entry_q;
        n_ret   = '0;
        for (int i = 0; i < 3; i++) begin
            if (bus.retire_en[i]) begin
                entry_d[ptr_add(tail_q, n_ret)] = bus.told_in[i];
                n_ret = n_ret + 2'd1;
            end
        end
        tail_d      = ptr_add(tail_q, n_ret);
        arch_head_d = ptr_add(arch_head_q, n_ret);
        if (bus.BPRecoverEN) begin
            // Every speculative allocation is returned: rewind to the retired frontier.
            head_d  = arch_head_d;
            count_d = CntW'(DEPTH);
        end else begin
            head_d  = ptr_add(head_q, n_grant);
            count_d = count_q - CntW'(n_grant) + CntW'(n_ret);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= PR'(ARCH_REGS + i);
            end
            head_q      <= '0;
            tail_q      <= '0;
            arch_head_q <= '0;
            count_q     <= CntW'(DEPTH);
        end else begin
            entry_q     <= entry_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            arch_head_q <= arch_head_d;
            count_q     <= count_d;
        end
    end

    assign bus.free_pr     = pr_sel;
    assign bus.alloc_grant = grant;
    assign bus.avail_num   = avail;
    assign bus.free_count  = count_q;

    a_count_max: assert property (@(posedge clock) disable iff (reset)
        count_q <= CntW'(DEPTH));
    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        (32'(count_q) + 32'(n_ret)) <= DEPTH);
    a_tail_arch: assert property (@(posedge clock) disable iff (reset)
        tail_q == arch_head_q);

    for (genvar g = 0; g < 3; g++) begin : g_told_chk
        a_told_valid: assert property (@(posedge clock) disable iff (reset)
            bus.retire_en[g] |-> (32'(bus.told_in[g]) < NUM_PR));
    end
endmodule
